// File: rtl/pdm_sd_modulator.sv
// Generic register FIFO; head entry is always presented on rd_dat.
// Latency: a pushed entry is visible to the reader on the following cycle.
// Backpressure: writes are ignored while full, reads ignored while empty.
module sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_en,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign rd_dat = mem[rd_ptr];
  assign do_wr  = wr_en && !full;
  assign do_rd  = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// First-order sigma-delta PDM modulator: 16-bit PCM in, one PDM bit per clk, each sample held HOLD clocks.
// Latency: a sample accepted at edge t first shapes pdm_out after edge t+3.
// Backpressure: pcm_in_ready = !full of a 2-entry FIFO; the bit stream itself never stalls.
module pdm_sd_modulator #(
  parameter int HOLD = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pcm_in,
  input  logic        pcm_in_valid,
  output logic        pcm_in_ready,
  output logic        pdm_out,
  output logic        busy,
  output logic        underrun
);
  localparam int CW = $clog2(HOLD);
  localparam logic [CW-1:0] LAST = CW'(HOLD - 1);
  localparam logic signed [17:0] FB_POS = 18'sd32768;
  localparam logic signed [17:0] FB_NEG = -18'sd32768;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               fifo_full;
  logic               fifo_empty;
  logic [15:0]        fifo_dat;
  logic               pop;
  logic               underrun_nxt;
  logic               hold_end;
  logic [CW-1:0]      hold_cnt;
  logic signed [15:0] x_cur;
  logic signed [17:0] acc;
  logic signed [17:0] x_ext;
  logic signed [17:0] fb;
  logic               pdm_bit;

  assign pcm_in_ready = !fifo_full;

  sync_fifo #(.W(16), .DEPTH(2)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (pcm_in_valid && pcm_in_ready),
    .wr_dat (pcm_in),
    .rd_en  (pop),
    .rd_dat (fifo_dat),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign hold_end = (hold_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = RUN;
      RUN:     if (hold_end && fifo_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop          = 1'b0;
    underrun_nxt = 1'b0;
    case (state)
      IDLE: pop = !fifo_empty;
      RUN: begin
        pop          = hold_end && !fifo_empty;
        underrun_nxt = hold_end && fifo_empty;
      end
      default: ;
    endcase
  end

  // Feedback is +/- full scale; the loop integrator carries over between samples and through IDLE.
  assign pdm_bit = !acc[17];
  assign x_ext   = {{2{x_cur[15]}}, x_cur};
  assign fb      = pdm_bit ? FB_POS : FB_NEG;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      x_cur    <= '0;
      hold_cnt <= '0;
      pdm_out  <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      pdm_out  <= pdm_bit;
      acc      <= acc + x_ext - fb;
      busy     <= (state_nxt == RUN);
      underrun <= underrun_nxt;
      if (pop) begin
        x_cur    <= fifo_dat;
        hold_cnt <= '0;
      end else if (state == RUN) begin
        hold_cnt <= hold_cnt + 1'b1;
        if (underrun_nxt) x_cur <= '0;
      end
    end
  end
endmodule

// File: tb/tb_pdm_sd_modulator.sv
// Scoreboard bench: stimulus queues expected window densities, busy intervals and underrun cycles;
// a negedge monitor pops and compares them against the live PDM stream.
module tb_pdm_sd_modulator;
  localparam int HOLD = 64;

  logic        clk;
  logic        rst_n;
  logic [15:0] pcm_in;
  logic        pcm_in_valid;
  logic        pcm_in_ready;
  logic        pdm_out;
  logic        busy;
  logic        underrun;

  pdm_sd_modulator #(.HOLD(HOLD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pcm_in       (pcm_in),
    .pcm_in_valid (pcm_in_valid),
    .pcm_in_ready (pcm_in_ready),
    .pdm_out      (pdm_out),
    .busy         (busy),
    .underrun     (underrun)
  );

  typedef struct {int start; int ones; int tol; logic [15:0] pcm;} win_t;
  typedef struct {int lo; int hi;} span_t;
  typedef struct {string name; logic pdm; logic bsy; logic rdy; logic ur;} bits_t;

  win_t  win_q[$];
  span_t busy_q[$];
  int    ur_q[$];
  bits_t exp_q[$];

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_load;
  int   acc_viol = 0;
  bit   mon_en;
  bit   win_open = 0;
  win_t cw;
  int   ones_cnt;
  int   nbits;
  int   ucyc;
  int   acc_now;
  bit   exp_busy;
  bits_t be;
  int   a;
  int   a0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // A sample accepted while a previous one is still being held chains onto the end of that hold.
  task automatic send(input logic [15:0] s, input int ones, input int tol, output int acc_cyc);
    int n;
    int ld;
    win_t w;
    span_t sp;
    pcm_in       = s;
    pcm_in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!pcm_in_ready && n < 400) begin
      n++;
      @(negedge clk);
    end
    if (!pcm_in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready=0 for %0d cycles expected 1", n);
    end
    acc_cyc = cyc + 1;
    ld = (acc_cyc < last_load + HOLD) ? last_load + HOLD : acc_cyc + 1;
    last_load = ld;
    w.start = ld + 2; w.ones = ones; w.tol = tol; w.pcm = s;
    win_q.push_back(w);
    sp.lo = ld; sp.hi = ld + HOLD;
    busy_q.push_back(sp);
    @(posedge clk); #1;
    pcm_in_valid = 1'b0;
  endtask

  task automatic expect_underrun();
    ur_q.push_back(last_load + HOLD);
  endtask

  task automatic push_bits(input string name, input logic p, input logic b, input logic r, input logic u);
    bits_t e;
    e.name = name; e.pdm = p; e.bsy = b; e.rdy = r; e.ur = u;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    pcm_in_valid = 1'b0;
    @(posedge clk); #1;
    win_q.delete(); busy_q.delete(); ur_q.delete();
    last_load = -1000;
    push_bits("reset_state", 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    push_bits("reset_hold", 1'b0, 1'b0, 1'b1, 1'b0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) push_bits($sformatf("silence_%0d", i), (i % 2) == 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((win_q.size() != 0 || win_open || ur_q.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL drain_%s: got %0d windows and %0d underruns pending expected 0", name, win_q.size(), ur_q.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) win_open = 1'b0;
    if (exp_q.size() != 0) begin
      be = exp_q.pop_front();
      checks++;
      if ({pdm_out, busy, pcm_in_ready, underrun} !== {be.pdm, be.bsy, be.rdy, be.ur}) begin
        errors++;
        $display("FAIL %s: got pdm/busy/ready/underrun=%b%b%b%b expected %b%b%b%b", be.name,
                 pdm_out, busy, pcm_in_ready, underrun, be.pdm, be.bsy, be.rdy, be.ur);
      end
    end
    if (rst_n && mon_en) begin
      while (busy_q.size() != 0 && cyc >= busy_q[0].hi) busy_q.delete(0);
      exp_busy = (busy_q.size() != 0) && (cyc >= busy_q[0].lo);
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy@%0d: got %b expected %b", cyc, busy, exp_busy);
      end

      if (underrun) begin
        checks++;
        if (ur_q.size() == 0) begin
          errors++;
          $display("FAIL underrun_unexpected@%0d: got 1 expected 0", cyc);
        end else begin
          ucyc = ur_q.pop_front();
          if (ucyc != cyc) begin
            errors++;
            $display("FAIL underrun_cycle: got %0d expected %0d", cyc, ucyc);
          end
        end
      end else if (ur_q.size() != 0 && ur_q[0] < cyc) begin
        checks++;
        errors++;
        $display("FAIL underrun_missing: got none expected at cycle %0d", ur_q[0]);
        ur_q.delete(0);
      end

      if (!win_open && win_q.size() != 0 && win_q[0].start < cyc) begin
        checks++;
        errors++;
        $display("FAIL window_missed: got none expected start at cycle %0d", win_q[0].start);
        win_q.delete(0);
      end
      if (!win_open && win_q.size() != 0 && win_q[0].start == cyc) begin
        cw = win_q.pop_front();
        win_open = 1'b1;
        ones_cnt = 0;
        nbits = 0;
      end
      if (win_open) begin
        ones_cnt += int'(pdm_out);
        nbits++;
        if (nbits == HOLD) begin
          checks++;
          if (ones_cnt < cw.ones - cw.tol || ones_cnt > cw.ones + cw.tol) begin
            errors++;
            $display("FAIL window_x%h: got %0d ones expected %0d +/- %0d", cw.pcm, ones_cnt, cw.ones, cw.tol);
          end
          win_open = 1'b0;
        end
      end

      acc_now = int'(dut.acc);
      if (acc_now < -65536 || acc_now > 65535) acc_viol++;
    end
  end

  initial begin
    rst_n = 1'b0;
    pcm_in = '0;
    pcm_in_valid = 1'b0;
    mon_en = 1'b0;
    last_load = -1000;

    do_reset();
    repeat (10) @(posedge clk);
    #1;
    drain("silence");

    send(16'h4000, 48, 1, a);
    expect_underrun();
    drain("single");

    send(16'h7FFF, 64, 1, a0);
    send(16'h8000, 0, 1, a);
    send(16'h0000, 32, 1, a);
    send(16'hC000, 16, 1, a);
    check_int("ready_reopen_cycle", a, a0 + 66);
    expect_underrun();
    drain("stream");

    repeat (3) send(16'h8000, 0, 0, a);
    expect_underrun();
    drain("fullscale_neg");

    repeat (4) send(16'h2000, 40, 1, a);
    expect_underrun();
    drain("loopback");

    repeat (3) send(16'h1000, 36, 1, a);
    check_int("fifo_full_ready", int'(pcm_in_ready), 0);
    repeat (20) @(posedge clk);
    #1;
    do_reset();
    repeat (80) @(posedge clk);
    #1;
    drain("after_reset");

    check_int("acc_range_violations", acc_viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pdm_sd_modulator.md
Name: pdm_sd_modulator

Overview:
- Transmit-side counterpart of the PDM-microphone decimator: converts 16-bit signed PCM samples into a 1-bit PDM stream, one bit per clk.
- Each accepted sample is held (zero-order hold) for HOLD clocks, matching the receiver's decimation factor of 64.
- A first-order sigma-delta loop produces the bits.
- Used as a loopback/test source for the decimator and as a PDM driver.
- Samples arrive through a valid/ready handshake into a 2-entry FIFO.

Parameters:
HOLD, 64, clocks each PCM sample is held; also the PDM bits produced per sample (power of two, 2..256)

Ports:
clk  input  1  main clock; one PDM bit per rising edge
rst_n  input  1  synchronous reset, active-low
pcm_in  input  16  signed PCM sample, two's complement
pcm_in_valid  input  1  pcm_in is valid this cycle
pcm_in_ready  output  1  FIFO can accept; transfer when valid & ready
pdm_out  output  1  registered PDM bit stream
busy  output  1  1 while in RUN state
underrun  output  1  one-cycle pulse: hold period ended with FIFO empty

Behaviour:
- Reset, on a clk edge with rst_n=0 (overrides all other activity, including a mid-sample hold):
  - FIFO emptied; acc=0; x_cur=0; hold_cnt=0; state=IDLE.
  - pdm_out=0, busy=0, underrun=0.
  - pcm_in_ready=1 from the first cycle after reset releases.
- FIFO: 2 entries, FIFO order; pcm_in_ready = !full (combinational from FIFO count only).
  - Push when pcm_in_valid & pcm_in_ready; sample is visible to the pop logic from the next cycle.
  - Push and pop in the same cycle are legal. Count is unchanged.
- Modulator, on every non-reset edge, in both states:
  - b = (acc >= 0).
  - pdm_out <= b.
  - acc <= acc + sext(x_cur) - (b ? 32768 : -32768).
  - acc is 18-bit signed. Range stays within [-65536, 65535]; no saturation logic is needed.
  - x_cur=0 gives 1,0,1,0,... (silence).
- State IDLE:
  - x_cur=0.
  - If FIFO non-empty: pop, load x_cur, set hold_cnt=0, go to RUN (all on that edge).
- State RUN:
  - hold_cnt increments every edge.
  - On the edge where hold_cnt==HOLD-1, if FIFO non-empty: pop, load x_cur, hold_cnt wraps to 0, stay in RUN. Samples stream gap-free: exactly HOLD bits per sample.
  - On the same edge, if FIFO empty: x_cur<=0, go to IDLE, assert underrun for one cycle.
- Latency:
  - Sample accepted at edge t (FIFO empty, IDLE).
  - Popped into x_cur at edge t+1.
  - First acc update using it at edge t+2.
  - First pdm_out bit influenced by it visible after edge t+3.
- busy is registered and equals (state==RUN).
- acc is not cleared between samples; the loop state carries over, including across IDLE.
- Density: over each HOLD window, the count of ones ≈ HOLD*(x+32768)/65536, within ±1.

Test Plan:
- Reset then idle, no input for 8 clocks -> pdm_out = 1,0,1,0,...; busy=0; pcm_in_ready=1; underrun never asserted.
- Push one sample 0x4000 (+16384) -> busy rises 1 cycle after acceptance; ones count over its 64-bit window = 48±1; underrun pulses exactly once, 64 cycles after load; returns to IDLE.
- Hold pcm_in_valid high with sequence 0x7FFF, 0x8000, 0x0000, 0xC000 -> pcm_in_ready drops while FIFO full; no gaps between windows (busy stays 1); ones per window = 64, 0, 32, 16 (each ±1); single underrun after the last window.
- Full-scale 0x8000 held -> pdm_out all 0 after settling; acc stays within 18-bit range (assertion on acc ∈ [-65536, 65535]).
- Assert rst_n=0 mid-window with FIFO holding 2 samples -> next cycle pdm_out=0, busy=0, pcm_in_ready=1; after release output resumes 1,0,1,0 silence.
- Loopback through the 64x decimator with constant 0x2000 -> decimated output is steady and proportional (ones density 40/64 = 0.625); no underrun while the source keeps valid high.
